// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: scan controller for the 8-digit common-anode display.
// Presents one nibble per slot on DIGIT for an external registered decoder and
// drives active-low anode enables. Each slot opens with a guard interval in which
// all anodes stay dark while the decoder output settles. The displayed value is
// double-buffered and switches only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned GUARD    = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] VALUE,
  input  logic        LOAD,
  input  logic [7:0]  EN_MASK,
  input  logic        LZ_BLANK,
  output logic [3:0]  DIGIT,
  output logic [7:0]  AN,
  output logic        PENDING,
  output logic        FRAME
);

  localparam int unsigned  CW       = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [31:0]   act, act_nxt;
  logic [31:0]   shd, shd_nxt;
  logic          pend_nxt;
  logic [3:0]    digit_nxt;
  logic [7:0]    an_nxt;
  logic          wrap, boundary;
  logic [31:0]   upper;
  logic          lead;

  // Slot end and frame end flags, derived directly from the registered counters.
  always_comb begin
    wrap     = (cnt == CNT_LAST);
    boundary = wrap && (idx == 3'd7);
  end

  assign FRAME = boundary;

  // Next-state logic. DIGIT and AN are computed from the next-cycle counter and
  // value so the registered outputs line up with the cycle they describe.
  always_comb begin
    cnt_nxt  = wrap ? '0 : cnt + CW'(1);
    idx_nxt  = wrap ? idx + 3'd1 : idx;
    act_nxt  = act;
    shd_nxt  = shd;
    pend_nxt = PENDING;
    if (LOAD) begin
      shd_nxt = VALUE;
    end
    if (boundary) begin
      // A load on the boundary itself bypasses the shadow and never raises PENDING.
      pend_nxt = 1'b0;
      if (LOAD) begin
        act_nxt = VALUE;
      end else if (PENDING) begin
        act_nxt = shd;
      end
    end else if (LOAD) begin
      pend_nxt = 1'b1;
    end

    digit_nxt = wrap ? act_nxt[{idx_nxt, 2'b00} +: 4] : DIGIT;

    upper = act_nxt >> {idx_nxt, 2'b00};
    lead  = LZ_BLANK && (idx_nxt != 3'd0) && (upper == '0);

    an_nxt = '1;
    if ((cnt_nxt >= GUARD_C) && EN_MASK[idx_nxt] && !lead) begin
      an_nxt[idx_nxt] = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt     <= '0;
      idx     <= '0;
      act     <= '0;
      shd     <= '0;
      PENDING <= 1'b0;
      DIGIT   <= '0;
      AN      <= '1;
    end else begin
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      act     <= act_nxt;
      shd     <= shd_nxt;
      PENDING <= pend_nxt;
      DIGIT   <= digit_nxt;
      AN      <= an_nxt;
    end
  end

endmodule
